// File: rtl/state_seq_monitor_pkg.sv
// Shared definitions for the LED state-sequence monitor: transition tables,
// speed thresholds and the tracking FSM encoding.
package state_seq_pkg;

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} fsm_state_t;

    // Lower bounds (exclusive) of the step period for speed codes 1..6
    localparam int unsigned SPD_T1 = 375;
    localparam int unsigned SPD_T2 = 208;
    localparam int unsigned SPD_T3 = 146;
    localparam int unsigned SPD_T4 = 112;
    localparam int unsigned SPD_T5 = 91;
    localparam int unsigned SPD_T6 = 77;

    function automatic logic [2:0] next_m0(input logic [2:0] s);
        logic [2:0] n;
        case (s)
            3'b000:  n = 3'b110;
            3'b001:  n = 3'b101;
            3'b010:  n = 3'b011;
            3'b011:  n = 3'b001;
            3'b100:  n = 3'b110;
            3'b101:  n = 3'b100;
            3'b110:  n = 3'b010;
            default: n = 3'b000;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] next_m1(input logic [2:0] s);
        logic [2:0] n;
        case (s)
            3'b000:  n = 3'b110;
            3'b001:  n = 3'b011;
            3'b010:  n = 3'b110;
            3'b011:  n = 3'b010;
            3'b100:  n = 3'b101;
            3'b101:  n = 3'b001;
            3'b110:  n = 3'b100;
            default: n = 3'b000;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] speed_class(input int unsigned p);
        logic [2:0] c;
        if (p > SPD_T1)      c = 3'd1;
        else if (p > SPD_T2) c = 3'd2;
        else if (p > SPD_T3) c = 3'd3;
        else if (p > SPD_T4) c = 3'd4;
        else if (p > SPD_T5) c = 3'd5;
        else if (p > SPD_T6) c = 3'd6;
        else                 c = 3'd7;
        return c;
    endfunction

endpackage

// File: rtl/state_seq_monitor_if.sv
// Monitor-side bundle: incoming LED state stream plus all tracking results.
interface state_seq_monitor_if #(
    parameter int unsigned PW   = 10,
    parameter int unsigned ERRW = 8
);
    logic [2:0]      data_in;
    logic            step;
    logic            locked;
    logic            seq_id;
    logic            err;
    logic [ERRW-1:0] err_cnt;
    logic [PW-1:0]   period;
    logic [2:0]      speed_est;
    logic            stalled;

    modport master (
        output data_in,
        input  step, locked, seq_id, err, err_cnt, period, speed_est, stalled
    );

    modport slave (
        input  data_in,
        output step, locked, seq_id, err, err_cnt, period, speed_est, stalled
    );
endinterface

// File: rtl/state_seq_monitor_period.sv
// Step-period measurement, stall timeout and speed-code recovery.
module state_seq_period
    import state_seq_pkg::*;
#(
    parameter int unsigned PW      = 10,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic          clk,
    input  logic          CR_n,
    input  logic          step,
    output logic [PW-1:0] period,
    output logic [2:0]    speed_est,
    output logic          stalled
);
    localparam logic [PW-1:0] TO = PW'(TIMEOUT);

    logic [PW-1:0] cyc_q;
    logic [PW-1:0] period_n;
    logic          seen_q;

    always_comb begin
        period_n = (cyc_q == '1) ? cyc_q : cyc_q + PW'(1);
    end

    // The first step after clear has no reference edge, so it only arms seen_q
    always_ff @(posedge clk or negedge CR_n) begin
        if (!CR_n) begin
            cyc_q     <= '0;
            seen_q    <= 1'b0;
            period    <= '0;
            speed_est <= '0;
            stalled   <= 1'b0;
        end else if (step) begin
            cyc_q   <= '0;
            seen_q  <= 1'b1;
            stalled <= 1'b0;
            if (seen_q) begin
                period    <= period_n;
                speed_est <= speed_class(32'(period_n));
            end
        end else begin
            if (cyc_q != '1) cyc_q <= cyc_q + PW'(1);
            if (cyc_q >= TO) begin
                stalled   <= 1'b1;
                speed_est <= '0;
            end
        end
    end

endmodule

// File: rtl/state_seq_monitor.sv
// Receive-side checker for the 3-bit LED state stream: synchronises, detects
// steps, identifies the running table and flags illegal transitions.
module state_seq_monitor
    import state_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_STEPS  = 4,
    parameter int unsigned PW          = 10,
    parameter int unsigned ERRW        = 8,
    parameter int unsigned TIMEOUT     = 1000
) (
    input  logic               clk,
    input  logic               CR_n,
    state_seq_monitor_if.slave mon
);
    localparam int unsigned CW = $clog2(LOCK_STEPS + 1);

    logic [2:0]      sync_q [SYNC_STAGES];
    logic [2:0]      ds;
    logic [2:0]      prev_q;
    logic            step_c;
    logic            leg0, leg1, leg_seq;
    logic [1:0]      cand_q, cand_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    fsm_state_t      state_q;
    logic            seq_q;
    logic            step_q, err_q, locked_q, seq_id_q;
    logic [ERRW-1:0] err_cnt_q;

    // Synchroniser clears to 111 to match prev_q, so no step fires on release
    always_ff @(posedge clk or negedge CR_n) begin
        if (!CR_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
        end else begin
            sync_q[0] <= mon.data_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_comb begin
        ds      = sync_q[SYNC_STAGES-1];
        step_c  = (ds != prev_q);
        leg0    = (next_m0(prev_q) == ds);
        leg1    = (next_m1(prev_q) == ds);
        leg_seq = seq_q ? leg1 : leg0;
        cand_n  = cand_q & {leg1, leg0};
        cnt_n   = (cnt_q == CW'(LOCK_STEPS)) ? cnt_q : cnt_q + CW'(1);
    end

    // IDLE scores its first step exactly like ACQ since cand starts as 2'b11
    always_ff @(posedge clk or negedge CR_n) begin
        if (!CR_n) begin
            state_q   <= IDLE;
            prev_q    <= '1;
            cand_q    <= 2'b11;
            cnt_q     <= '0;
            seq_q     <= 1'b0;
            step_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            locked_q  <= 1'b0;
            seq_id_q  <= 1'b0;
        end else begin
            step_q   <= step_c;
            err_q    <= 1'b0;
            locked_q <= (state_q == LOCKED);
            seq_id_q <= (state_q == LOCKED) && seq_q;
            if (step_c) begin
                prev_q <= ds;
                case (state_q)
                    IDLE, ACQ: begin
                        if (cand_n == 2'b00) begin
                            cand_q  <= 2'b11;
                            cnt_q   <= '0;
                            state_q <= ACQ;
                        end else begin
                            cand_q <= cand_n;
                            cnt_q  <= cnt_n;
                            if (cnt_n >= CW'(LOCK_STEPS) && (cand_n[0] ^ cand_n[1])) begin
                                state_q <= LOCKED;
                                seq_q   <= cand_n[1];
                            end else begin
                                state_q <= ACQ;
                            end
                        end
                    end
                    LOCKED: begin
                        if (!leg_seq) begin
                            err_q <= 1'b1;
                            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERRW'(1);
                            state_q <= ACQ;
                            cand_q  <= 2'b11;
                            cnt_q   <= '0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    state_seq_period #(
        .PW      (PW),
        .TIMEOUT (TIMEOUT)
    ) u_period (
        .clk       (clk),
        .CR_n      (CR_n),
        .step      (step_q),
        .period    (mon.period),
        .speed_est (mon.speed_est),
        .stalled   (mon.stalled)
    );

    assign mon.step    = step_q;
    assign mon.err     = err_q;
    assign mon.err_cnt = err_cnt_q;
    assign mon.locked  = locked_q;
    assign mon.seq_id  = seq_id_q;

endmodule

// File: tb/tb_state_seq_monitor.sv
// Scoreboard bench for state_seq_monitor: directed LED streams with
// hand-computed per-step expectations, checked by an independent monitor.
module tb_state_seq_monitor;

    logic clk;
    logic CR_n;

    state_seq_monitor_if #(.PW(10), .ERRW(8)) mon_if ();

    state_seq_monitor #(
        .SYNC_STAGES (2),
        .LOCK_STEPS  (4),
        .PW          (10),
        .ERRW        (8),
        .TIMEOUT     (1000)
    ) dut (
        .clk  (clk),
        .CR_n (CR_n),
        .mon  (mon_if.slave)
    );

    typedef struct {
        logic        err;
        logic        locked;
        logic        seq;
        int unsigned period;
        int unsigned speed;
        int unsigned ecnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_step"},    32'(mon_if.step), 0);
        chk({tag, "_err"},     32'(mon_if.err), 0);
        chk({tag, "_locked"},  32'(mon_if.locked), 0);
        chk({tag, "_seq_id"},  32'(mon_if.seq_id), 0);
        chk({tag, "_err_cnt"}, 32'(mon_if.err_cnt), 0);
        chk({tag, "_period"},  32'(mon_if.period), 0);
        chk({tag, "_speed"},   32'(mon_if.speed_est), 0);
        chk({tag, "_stalled"}, 32'(mon_if.stalled), 0);
    endtask

    // Drive a new LED state, queue what the monitor must see for that step,
    // then hold the state for gap cycles.
    task automatic issue(input logic [2:0] v, input int gap, input logic e_err,
                         input logic e_lk, input logic e_seq, input int unsigned e_per,
                         input int unsigned e_spd, input int unsigned e_ec);
        exp_t e;
        e.err = e_err; e.locked = e_lk; e.seq = e_seq;
        e.period = e_per; e.speed = e_spd; e.ecnt = e_ec;
        exp_q.push_back(e);
        mon_if.data_in = v;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        CR_n = 1'b0;
        mon_if.data_in = 3'b111;
        #1;
        check_all_zero(tag);
        repeat (3) @(negedge clk);
        CR_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // Monitor: err is judged on the step cycle, tracking results one cycle later
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (CR_n) begin
                if (mon_if.err && !mon_if.step) chk("err_without_step", 1, 0);
                if (mon_if.step) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_step", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("err", 32'(mon_if.err), 32'(e.err));
                        @(negedge clk);
                        chk("locked",  32'(mon_if.locked), 32'(e.locked));
                        chk("seq_id",  32'(mon_if.seq_id), 32'(e.seq));
                        chk("period",  32'(mon_if.period), e.period);
                        chk("speed",   32'(mon_if.speed_est), e.speed);
                        chk("stalled", 32'(mon_if.stalled), 0);
                        chk("err_cnt", 32'(mon_if.err_cnt), e.ecnt);
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        CR_n = 1'b0;
        mon_if.data_in = 3'b111;

        // Reset held with a toggling stream: outputs stay clear
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mon_if.data_in = 3'($urandom_range(0, 7));
        end
        #1;
        check_all_zero("in_reset");
        mon_if.data_in = 3'b111;
        repeat (2) @(negedge clk);
        CR_n = 1'b1;
        repeat (20) @(negedge clk);
        check_all_zero("after_release");

        // M=0 stream at 125 cycles/step, locks on the 4th step
        issue(3'b000, 125, 0, 0, 0,   0, 0, 0);
        issue(3'b110, 125, 0, 0, 0, 125, 4, 0);
        issue(3'b010, 125, 0, 0, 0, 125, 4, 0);
        issue(3'b011, 125, 0, 1, 0, 125, 4, 0);
        issue(3'b001, 125, 0, 1, 0, 125, 4, 0);
        issue(3'b101, 125, 0, 1, 0, 125, 4, 0);
        issue(3'b100, 125, 0, 1, 0, 125, 4, 0);
        issue(3'b110, 125, 0, 1, 0, 125, 4, 0);
        issue(3'b010, 125, 0, 1, 0, 125, 4, 0);
        issue(3'b011, 125, 0, 1, 0, 125, 4, 0);
        // Illegal 011>110, then relock after four legal steps
        issue(3'b110, 125, 1, 0, 0, 125, 4, 1);
        issue(3'b010, 125, 0, 0, 0, 125, 4, 1);
        issue(3'b011, 125, 0, 0, 0, 125, 4, 1);
        issue(3'b001, 125, 0, 0, 0, 125, 4, 1);
        issue(3'b101, 125, 0, 1, 0, 125, 4, 1);

        // Stall: 101 has been held 125 cycles so far
        repeat (855) @(negedge clk);
        chk("stalled_early", 32'(mon_if.stalled), 0);
        chk("speed_early",   32'(mon_if.speed_est), 4);
        repeat (70) @(negedge clk);
        chk("stalled_set",   32'(mon_if.stalled), 1);
        chk("speed_stalled", 32'(mon_if.speed_est), 0);
        chk("locked_stall",  32'(mon_if.locked), 1);
        repeat (50) @(negedge clk);
        issue(3'b100, 125, 0, 1, 0, 1023, 1, 1);
        chk("stalled_clear", 32'(mon_if.stalled), 0);

        // M=1 stream at 250 cycles/step
        do_reset("rst_m1");
        issue(3'b000, 250, 0, 0, 0,   0, 0, 0);
        issue(3'b110, 250, 0, 0, 0, 250, 2, 0);
        issue(3'b100, 250, 0, 0, 0, 250, 2, 0);
        issue(3'b101, 250, 0, 1, 1, 250, 2, 0);
        issue(3'b001, 250, 0, 1, 1, 250, 2, 0);
        issue(3'b011, 250, 0, 1, 1, 250, 2, 0);

        // Fast M=0 stream, three illegal events, then asynchronous clear
        do_reset("rst_fast");
        issue(3'b000, 8, 0, 0, 0, 0, 0, 0);
        issue(3'b110, 8, 0, 0, 0, 8, 7, 0);
        issue(3'b010, 8, 0, 0, 0, 8, 7, 0);
        issue(3'b011, 8, 0, 1, 0, 8, 7, 0);
        issue(3'b001, 8, 0, 1, 0, 8, 7, 0);
        issue(3'b101, 8, 0, 1, 0, 8, 7, 0);
        for (int k = 1; k <= 3; k++) begin
            issue(3'b110, 8, 1, 0, 0, 8, 7, 32'(k));
            issue(3'b010, 8, 0, 0, 0, 8, 7, 32'(k));
            issue(3'b011, 8, 0, 0, 0, 8, 7, 32'(k));
            issue(3'b001, 8, 0, 0, 0, 8, 7, 32'(k));
            issue(3'b101, 8, 0, 1, 0, 8, 7, 32'(k));
        end
        chk("err_cnt_3", 32'(mon_if.err_cnt), 3);
        chk("locked_3",  32'(mon_if.locked), 1);
        do_reset("rst_locked");

        // 2**ERRW+2 illegal events: err_cnt must stick at 255
        issue(3'b000, 8, 0, 0, 0, 0, 0, 0);
        issue(3'b110, 8, 0, 0, 0, 8, 7, 0);
        issue(3'b010, 8, 0, 0, 0, 8, 7, 0);
        issue(3'b011, 8, 0, 1, 0, 8, 7, 0);
        issue(3'b001, 8, 0, 1, 0, 8, 7, 0);
        issue(3'b101, 8, 0, 1, 0, 8, 7, 0);
        for (int k = 1; k <= 258; k++) begin
            int unsigned ec;
            ec = (k > 255) ? 255 : 32'(k);
            issue(3'b110, 8, 1, 0, 0, 8, 7, ec);
            issue(3'b010, 8, 0, 0, 0, 8, 7, ec);
            issue(3'b011, 8, 0, 0, 0, 8, 7, ec);
            issue(3'b001, 8, 0, 0, 0, 8, 7, ec);
            issue(3'b101, 8, 0, 1, 0, 8, 7, ec);
        end
        chk("err_cnt_sat", 32'(mon_if.err_cnt), 255);

        repeat (20) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
